// File: rtl/nibble_deser.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : nibble_deser                                                |
// | Description : Framed serial-to-parallel receiver for the nibble link.     |
// |               Recovers 4 data bits onto registered A..D, LSB (A) first,   |
// |               and pulses valid / frame_err / parity_err for one cycle.    |
// |               Define PARITY_EN to compile in the even-parity bit check.   |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module nibble_deser #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic A,
    output logic B,
    output logic C,
    output logic D,
    output logic valid,
    output logic frame_err,
    output logic parity_err
);

    localparam int             c_CW        = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    // Down-counter reload values: first sample lands mid-bit, later ones a full bit apart.
    localparam logic [c_CW-1:0] c_LOAD_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_LOAD_BIT  = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_BREAK  = 3'd5;

    logic            r_din_q;
    logic [2:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [1:0]      r_idx;
    logic [3:0]      r_sr;
    logic            r_a;
    logic            r_b;
    logic            r_c;
    logic            r_d;
    logic            r_valid;
    logic            r_frame_err;
`ifdef PARITY_EN
    logic            r_par_bad;
    logic            r_parity_err;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_din_q      <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_idx        <= '0;
            r_sr         <= '0;
            r_a          <= 1'b0;
            r_b          <= 1'b0;
            r_c          <= 1'b0;
            r_d          <= 1'b0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef PARITY_EN
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_din_q     <= din;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
`ifdef PARITY_EN
            r_parity_err <= 1'b0;
`endif
            case (r_state)
                S_IDLE: begin
                    if (!r_din_q) begin
                        r_state <= S_START;
                        r_cnt   <= c_LOAD_HALF;
                    end
                end
                S_START: begin
                    if (r_cnt == '0) begin
                        // A start bit that is already high mid-bit was a glitch.
                        if (r_din_q) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state <= S_DATA;
                            r_cnt   <= c_LOAD_BIT;
                            r_idx   <= '0;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == '0) begin
                        r_sr  <= {r_din_q, r_sr[3:1]};
                        r_cnt <= c_LOAD_BIT;
                        if (r_idx == 2'd3) begin
                            r_idx <= '0;
`ifdef PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`ifdef PARITY_EN
                S_PARITY: begin
                    if (r_cnt == '0) begin
                        r_par_bad <= r_din_q ^ (^r_sr);
                        r_cnt     <= c_LOAD_BIT;
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (r_cnt == '0) begin
                        if (r_din_q) begin
`ifdef PARITY_EN
                            if (r_par_bad) begin
                                r_parity_err <= 1'b1;
                            end else begin
                                {r_d, r_c, r_b, r_a} <= r_sr;
                                r_valid <= 1'b1;
                            end
`else
                            {r_d, r_c, r_b, r_a} <= r_sr;
                            r_valid <= 1'b1;
`endif
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_BREAK;
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_BREAK: begin
                    // Only a return to idle-high re-arms start detection.
                    if (r_din_q) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign A         = r_a;
    assign B         = r_b;
    assign C         = r_c;
    assign D         = r_d;
    assign valid     = r_valid;
    assign frame_err = r_frame_err;
`ifdef PARITY_EN
    assign parity_err = r_parity_err;
`else
    assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nibble_deser.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module      : tb_nibble_deser                                             |
// | Description : Directed self-checking bench for nibble_deser (CPB = 4).    |
// | Revision    : 1.0 - initial release                                       |
// +---------------------------------------------------------------------------+
module tb_nibble_deser;

    localparam int CPB = 4;
`ifdef PARITY_EN
    localparam int LAT  = 28;  // cycle 27 relative to cycle 0, plus din register
    localparam int FLEN = 28;
`else
    localparam int LAT  = 24;  // cycle 23 relative to cycle 0, plus din register
    localparam int FLEN = 24;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic din = 1'b1;
    logic A, B, C, D, valid, frame_err, parity_err;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_valid = 0;
    int n_ferr = 0;
    int n_perr = 0;
    int n_multi = 0;
    int f_cyc = 0;
    int p_cyc = 0;
    int v_cyc[64];
    logic [3:0] v_data[64];

    nibble_deser #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .din(din),
        .A(A), .B(B), .C(C), .D(D),
        .valid(valid), .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (valid) begin
            if (n_valid < 64) begin
                v_cyc[n_valid]  = cyc;
                v_data[n_valid] = {D, C, B, A};
            end
            n_valid++;
        end
        if (frame_err) begin
            n_ferr++;
            f_cyc = cyc;
        end
        if (parity_err) begin
            n_perr++;
            p_cyc = cyc;
        end
        if ((32'(valid) + 32'(frame_err) + 32'(parity_err)) > 1) n_multi++;
    end

    // Called on a negedge; returns on the negedge where the stop bit ends.
    task automatic send_frame(input logic [3:0] data, input logic par,
                              input logic stop, output int t0);
        t0  = cyc;
        din = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            din = data[i];
            repeat (CPB) @(negedge clk);
        end
`ifdef PARITY_EN
        din = par;
        repeat (CPB) @(negedge clk);
`else
        if (par) din = 1'b1;
`endif
        din = stop;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({A, B, C, D, valid, frame_err, parity_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {A, B, C, D, valid, frame_err, parity_err});
        end
        rst = 1'b1;
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({A, B, C, D, valid, frame_err, parity_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL idle_after_reset: got %b expected 0000000",
                     {A, B, C, D, valid, frame_err, parity_err});
        end
    endtask

    task automatic test_good_frame;
        int t0;
        int nv0;
        nv0 = n_valid;
        send_frame(4'b1010, 1'b0, 1'b1, t0);
        din = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if (n_valid !== nv0 + 1) begin
            n_bad++;
            $display("FAIL good_valid_count: got %0d expected %0d", n_valid - nv0, 1);
        end
        n_cmp++;
        if (v_cyc[nv0] !== t0 + LAT) begin
            n_bad++;
            $display("FAIL good_valid_cycle: got %0d expected %0d", v_cyc[nv0] - t0, LAT);
        end
        n_cmp++;
        if (v_data[nv0] !== 4'b1010) begin
            n_bad++;
            $display("FAIL good_data: got %b expected 1010", v_data[nv0]);
        end
        n_cmp++;
        if (n_ferr !== 0) begin
            n_bad++;
            $display("FAIL good_no_frame_err: got %0d expected 0", n_ferr);
        end
    endtask

    task automatic test_glitch;
        int nv0, nf0, np0;
        nv0 = n_valid; nf0 = n_ferr; np0 = n_perr;
        din = 1'b0;
        @(negedge clk);
        din = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if ((n_valid - nv0) + (n_ferr - nf0) + (n_perr - np0) !== 0) begin
            n_bad++;
            $display("FAIL glitch_strobes: got %0d expected 0",
                     (n_valid - nv0) + (n_ferr - nf0) + (n_perr - np0));
        end
        n_cmp++;
        if ({D, C, B, A} !== 4'b1010) begin
            n_bad++;
            $display("FAIL glitch_data_hold: got %b expected 1010", {D, C, B, A});
        end
    endtask

    task automatic test_frame_err;
        int t0;
        int nv0, nf0;
        nv0 = n_valid; nf0 = n_ferr;
        send_frame(4'b1111, 1'b0, 1'b0, t0);
        repeat (10) @(negedge clk);
        #1;
        n_cmp++;
        if (n_ferr !== nf0 + 1) begin
            n_bad++;
            $display("FAIL ferr_count: got %0d expected 1", n_ferr - nf0);
        end
        n_cmp++;
        if (f_cyc !== t0 + LAT) begin
            n_bad++;
            $display("FAIL ferr_cycle: got %0d expected %0d", f_cyc - t0, LAT);
        end
        n_cmp++;
        if ({D, C, B, A} !== 4'b1010) begin
            n_bad++;
            $display("FAIL ferr_data_hold: got %b expected 1010", {D, C, B, A});
        end
        @(negedge clk);
        din = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if ((n_valid !== nv0) || (n_ferr !== nf0 + 1)) begin
            n_bad++;
            $display("FAIL break_no_new_frame: got valid %0d ferr %0d expected 0 1",
                     n_valid - nv0, n_ferr - nf0);
        end
    endtask

`ifdef PARITY_EN
    task automatic test_parity;
        int t0;
        int nv0, np0;
        nv0 = n_valid; np0 = n_perr;
        send_frame(4'b0110, 1'b1, 1'b1, t0);
        din = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if ((n_perr !== np0 + 1) || (p_cyc !== t0 + LAT)) begin
            n_bad++;
            $display("FAIL parity_err_pulse: got count %0d at %0d expected 1 at %0d",
                     n_perr - np0, p_cyc - t0, LAT);
        end
        n_cmp++;
        if ({D, C, B, A} !== 4'b1010 || n_valid !== nv0) begin
            n_bad++;
            $display("FAIL parity_data_hold: got %b expected 1010", {D, C, B, A});
        end
        send_frame(4'b0110, 1'b0, 1'b1, t0);
        din = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if ((n_valid !== nv0 + 1) || (v_cyc[nv0] !== t0 + LAT) || (v_data[nv0] !== 4'b0110)) begin
            n_bad++;
            $display("FAIL parity_good_frame: got count %0d data %b expected 1 data 0110",
                     n_valid - nv0, v_data[nv0]);
        end
    endtask
`endif

    task automatic test_back_to_back;
        int t0, t1;
        int nv0;
        nv0 = n_valid;
        send_frame(4'b0001, 1'b1, 1'b1, t0);
        send_frame(4'b1000, 1'b1, 1'b1, t1);
        din = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if (n_valid !== nv0 + 2) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d expected 2", n_valid - nv0);
        end
        n_cmp++;
        if (v_cyc[nv0 + 1] - v_cyc[nv0] !== FLEN) begin
            n_bad++;
            $display("FAIL b2b_spacing: got %0d expected %0d",
                     v_cyc[nv0 + 1] - v_cyc[nv0], FLEN);
        end
        n_cmp++;
        if (v_data[nv0] !== 4'b0001) begin
            n_bad++;
            $display("FAIL b2b_first_data: got %b expected 0001", v_data[nv0]);
        end
        n_cmp++;
        if (v_data[nv0 + 1] !== 4'b1000) begin
            n_bad++;
            $display("FAIL b2b_second_data: got %b expected 1000", v_data[nv0 + 1]);
        end
    endtask

    task automatic test_reset_mid;
        int t0;
        int nv0;
        nv0 = n_valid;
        din = 1'b0;
        repeat (CPB) @(negedge clk);
        din = 1'b1;
        repeat (CPB) @(negedge clk);
        din = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({A, B, C, D, valid, frame_err, parity_err} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got %b expected 0000000",
                     {A, B, C, D, valid, frame_err, parity_err});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        n_cmp++;
        if (n_valid !== nv0) begin
            n_bad++;
            $display("FAIL reset_mid_no_strobe: got %0d expected 0", n_valid - nv0);
        end
        @(negedge clk);
        send_frame(4'b0011, 1'b0, 1'b1, t0);
        din = 1'b1;
        repeat (8) @(negedge clk);
        #1;
        n_cmp++;
        if ((n_valid !== nv0 + 1) || (v_data[nv0] !== 4'b0011)) begin
            n_bad++;
            $display("FAIL reset_mid_fresh_frame: got count %0d data %b expected 1 data 0011",
                     n_valid - nv0, v_data[nv0]);
        end
        n_cmp++;
        if (n_multi !== 0) begin
            n_bad++;
            $display("FAIL strobe_exclusive: got %0d overlaps expected 0", n_multi);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_glitch();
        test_frame_err();
`ifdef PARITY_EN
        test_parity();
`endif
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
